bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Two-master, one-slave arbiter for the CPU memory bus (addr/data, wr_valid/wr_ready, rd_ready/rd_valid).
//  Sits between the core (M0) and a second requester such as a UART loader or DMA (M1), and the memmap slave port.
//  Does round-robin grant, holds the grant for one whole transaction, and aborts stalled slaves via a timeout.
// PARAMETERS
//  DATA_WIDTH      32   data bus width
//  TIMEOUT_CYCLES  256  cycles granted without a handshake before forced completion; 0 disables the timeout
// PORTS
//  i_clk           in   1           clock
//  i_rst           in   1           asynchronous reset, active-high
//  i_m0_addr       in   32          M0 address
//  i_m0_data       in   DATA_WIDTH  M0 write data
//  i_m0_wr_valid   in   1           M0 write request
//  o_m0_wr_ready   out  1           M0 write accepted
//  o_m0_data       out  DATA_WIDTH  M0 read data
//  o_m0_rd_valid   out  1           M0 read data valid
//  i_m0_rd_ready   in   1           M0 read request
//  i_m1_*/o_m1_*   -    -           M1 ports, identical set to M0
//  o_s_addr        out  32          slave address
//  o_s_data        out  DATA_WIDTH  slave write data
//  o_s_wr_valid    out  1           slave write request
//  i_s_wr_ready    in   1           slave write accepted
//  i_s_data        in   DATA_WIDTH  slave read data
//  i_s_rd_valid    in   1           slave read data valid
//  o_s_rd_ready    out  1           slave read request
//  o_grant         out  2           one-hot current grant; 00 = idle
//  o_timeout       out  1           one-cycle pulse on forced completion
// BEHAVIOUR
//  Request and handshake definitions
//  - Master n requests when wr_valid | rd_ready. If both are high, the write wins and rd_ready is ignored.
//  - A handshake is (wr_valid & wr_ready) or (rd_ready & rd_valid) on the granted side.
//  State machine: IDLE, GNT0, GNT1
//  - IDLE, one requester: grant it next cycle.
//  - IDLE, both requesting: grant the master not served last.
//  - last_grant resets to 1, so M0 wins the first tie.
//  - GNTn, slave handshake: go to IDLE next cycle; last_grant <= n.
//  - GNTn, master n drops its request before a handshake: abort, go to IDLE next cycle; last_grant unchanged; no pulse.
//  - GNTn, timeout counter == TIMEOUT_CYCLES-1 with no handshake (TIMEOUT_CYCLES > 0):
//    - this cycle: slave side is driven 0.
//    - this cycle: master n gets wr_ready=1 (write) or rd_valid=1 with data 0 (read).
//    - this cycle: o_timeout=1.
//    - next cycle: go to IDLE; last_grant <= n.
//  Datapath
//  - Datapath is combinational, selected by the registered state.
//  - In GNTn, slave outputs = master n inputs; master n outputs = slave inputs.
//  - The non-granted master and all IDLE outputs are 0 (valid/ready 0, data 0).
//  Latency and throughput
//  - Request to slave visibility: 1 cycle.
//  - Slave handshake to master: same cycle.
//  - At least one IDLE cycle between transactions; max throughput is 1 transaction per 2 cycles.
//  Timeout counter
//  - Width $clog2(TIMEOUT_CYCLES+1).
//  - Cleared in IDLE and on entering GNTn; increments each granted cycle without a handshake.
//  - Never wraps.
//  Starvation
//  - A master waiting in IDLE is guaranteed the next grant after at most one transaction by the other master.
//  Reset
//  - Asynchronous; legal mid-transaction.
//  - Forces IDLE, counter 0, last_grant 1.
//  - All outputs 0, including o_grant=00 and o_timeout=0.
//  - The in-flight transaction is dropped silently.
// TESTING
//  - M0 write addr 0xFFFF data 0x41, slave wr_ready=1 -> o_s_wr_valid rises 1 cycle later; o_m0_wr_ready same cycle; o_grant 01->00.
//  - M0 and M1 both request reads from reset -> order is M0, M1, M0, M1; each grant is separated by one IDLE cycle.
//  - Slave returns rd_valid with 0xDEADBEEF for M1 -> o_m1_rd_data=0xDEADBEEF; o_m0_rd_valid stays 0 throughout.
//  - TIMEOUT_CYCLES=4, slave never ready:
//    - o_timeout pulses in the 4th granted cycle, with o_m0_rd_valid=1 and data 0.
//    - next cycle is IDLE.
//  - Reset asserted mid-grant (GNT1):
//    - all outputs are 0 immediately, without waiting for a clock edge.
//    - after release, a tie grants M0 first.
//  - M1 drops its request in GNT1 before any handshake -> IDLE next cycle; o_timeout=0; a pending M0 is granted next.

Source files
------------

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Two-master / one-slave arbiter for the CPU memory bus. M0 is normally the
//   core, M1 a secondary requester (loader, DMA). Grants are round-robin and are
//   held for exactly one transaction (one write or one read handshake). A
//   stalled slave is cut loose after TIMEOUT_CYCLES granted cycles: the master
//   is completed locally (write accepted, or read returning zero) and o_timeout
//   pulses.
//
// Parameters
//   DATA_WIDTH      data bus width
//   TIMEOUT_CYCLES  granted cycles without a handshake before forced completion
//                   (0 disables the timeout)
//
// Ports
//   i_clk, i_rst                   clock, asynchronous active-high reset
//   i_mN_addr / i_mN_data          master N address / write data
//   i_mN_wr_valid / o_mN_wr_ready  master N write request / accept
//   i_mN_rd_ready / o_mN_rd_valid  master N read request / read data valid
//   o_mN_data                      master N read data
//   o_s_*/i_s_*                    slave port (same signal set, reversed)
//   o_grant                        one-hot current grant, 00 when idle
//   o_timeout                      one-cycle pulse on forced completion
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    // master 0
    input  logic [31:0]           i_m0_addr,
    input  logic [DATA_WIDTH-1:0] i_m0_data,
    input  logic                  i_m0_wr_valid,
    output logic                  o_m0_wr_ready,
    output logic [DATA_WIDTH-1:0] o_m0_data,
    output logic                  o_m0_rd_valid,
    input  logic                  i_m0_rd_ready,
    // master 1
    input  logic [31:0]           i_m1_addr,
    input  logic [DATA_WIDTH-1:0] i_m1_data,
    input  logic                  i_m1_wr_valid,
    output logic                  o_m1_wr_ready,
    output logic [DATA_WIDTH-1:0] o_m1_data,
    output logic                  o_m1_rd_valid,
    input  logic                  i_m1_rd_ready,
    // slave
    output logic [31:0]           o_s_addr,
    output logic [DATA_WIDTH-1:0] o_s_data,
    output logic                  o_s_wr_valid,
    input  logic                  i_s_wr_ready,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    input  logic                  i_s_rd_valid,
    output logic                  o_s_rd_ready,
    // status
    output logic [1:0]            o_grant,
    output logic                  o_timeout
);

    // A zero-width counter is illegal, so the disabled case keeps one bit.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t           state_reg;
    logic             last_grant_reg;   // index of the master served last
    logic [CNT_W-1:0] cnt_reg;

    // Master inputs gathered into arrays so the per-master logic is uniform.
    logic [1:0]                 m_wr_valid;
    logic [1:0]                 m_rd_ready;
    logic [1:0]                 m_req;
    logic [1:0]                 m_is_rd;
    logic [1:0][31:0]           m_addr;
    logic [1:0][DATA_WIDTH-1:0] m_data;

    assign m_wr_valid = {i_m1_wr_valid, i_m0_wr_valid};
    assign m_rd_ready = {i_m1_rd_ready, i_m0_rd_ready};
    assign m_addr     = {i_m1_addr, i_m0_addr};
    assign m_data     = {i_m1_data, i_m0_data};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign m_req[gi]   = m_wr_valid[gi] | m_rd_ready[gi];
            // A simultaneous write wins; the read request is ignored.
            assign m_is_rd[gi] = m_rd_ready[gi] & ~m_wr_valid[gi];
        end
    endgenerate

    // Granted-side decode, driven only by the registered state.
    logic [1:0] grant_vec;
    logic       granted;
    logic       sel;
    logic       sel_wr;
    logic       sel_rd;
    logic       sel_req;
    logic       handshake;
    logic       timeout_hit;
    logic       pass;

    assign grant_vec = {state_reg == GNT1, state_reg == GNT0};
    assign granted   = |grant_vec;
    assign sel       = grant_vec[1];
    assign sel_wr    = granted & m_wr_valid[sel];
    assign sel_rd    = granted & m_is_rd[sel];
    assign sel_req   = sel_wr | sel_rd;
    assign handshake = (sel_wr & i_s_wr_ready) | (sel_rd & i_s_rd_valid);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            assign timeout_hit = sel_req & ~handshake & (cnt_reg == CNT_LAST);
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // During the forced-completion cycle the slave is disconnected entirely.
    assign pass = granted & ~timeout_hit;

    assign o_s_addr     = pass ? m_addr[sel] : '0;
    assign o_s_data     = pass ? m_data[sel] : '0;
    assign o_s_wr_valid = pass & sel_wr;
    assign o_s_rd_ready = pass & sel_rd;

    logic [1:0]                 mo_wr_ready;
    logic [1:0]                 mo_rd_valid;
    logic [1:0][DATA_WIDTH-1:0] mo_data;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_mout
            // On timeout the master is completed locally: write accepted, or
            // read valid with zero data.
            assign mo_wr_ready[gi] = grant_vec[gi] & (timeout_hit ? m_wr_valid[gi] : i_s_wr_ready);
            assign mo_rd_valid[gi] = grant_vec[gi] & (timeout_hit ? m_is_rd[gi] : i_s_rd_valid);
            assign mo_data[gi]     = (grant_vec[gi] & ~timeout_hit) ? i_s_data : '0;
        end
    endgenerate

    assign o_m0_wr_ready = mo_wr_ready[0];
    assign o_m0_rd_valid = mo_rd_valid[0];
    assign o_m0_data     = mo_data[0];
    assign o_m1_wr_ready = mo_wr_ready[1];
    assign o_m1_rd_valid = mo_rd_valid[1];
    assign o_m1_data     = mo_data[1];

    assign o_grant   = grant_vec;
    assign o_timeout = timeout_hit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;     // M0 wins the first tie
            cnt_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (m_req[0] && (!m_req[1] || last_grant_reg)) begin
                        state_reg <= GNT0;
                    end else if (m_req[1]) begin
                        state_reg <= GNT1;
                    end
                end
                GNT0, GNT1: begin
                    if (handshake || timeout_hit) begin
                        state_reg      <= IDLE;
                        last_grant_reg <= sel;
                        cnt_reg        <= '0;
                    end else if (!sel_req) begin
                        // Master withdrew: abort without touching fairness.
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk;
    logic          rst;
    logic          m_wv    [2];
    logic          m_rr    [2];
    logic [31:0]   m_addr  [2];
    logic [DW-1:0] m_wdata [2];
    logic          s_wr_ready;
    logic          s_rd_valid;
    logic [DW-1:0] s_rdata;

    wire [1:0]    dut_grant;
    wire          dut_timeout;
    wire [31:0]   dut_s_addr;
    wire [DW-1:0] dut_s_data;
    wire          dut_s_wr_valid;
    wire          dut_s_rd_ready;
    wire          dut_m0_wr_ready, dut_m0_rd_valid;
    wire          dut_m1_wr_ready, dut_m1_rd_valid;
    wire [DW-1:0] dut_m0_data, dut_m1_data;

    bus_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_m0_addr    (m_addr[0]),
        .i_m0_data    (m_wdata[0]),
        .i_m0_wr_valid(m_wv[0]),
        .o_m0_wr_ready(dut_m0_wr_ready),
        .o_m0_data    (dut_m0_data),
        .o_m0_rd_valid(dut_m0_rd_valid),
        .i_m0_rd_ready(m_rr[0]),
        .i_m1_addr    (m_addr[1]),
        .i_m1_data    (m_wdata[1]),
        .i_m1_wr_valid(m_wv[1]),
        .o_m1_wr_ready(dut_m1_wr_ready),
        .o_m1_data    (dut_m1_data),
        .o_m1_rd_valid(dut_m1_rd_valid),
        .i_m1_rd_ready(m_rr[1]),
        .o_s_addr     (dut_s_addr),
        .o_s_data     (dut_s_data),
        .o_s_wr_valid (dut_s_wr_valid),
        .i_s_wr_ready (s_wr_ready),
        .i_s_data     (s_rdata),
        .i_s_rd_valid (s_rd_valid),
        .o_s_rd_ready (dut_s_rd_ready),
        .o_grant      (dut_grant),
        .o_timeout    (dut_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bus, how long it has waited, who was served last.
    int owner;        // 0 = nobody, 1 = M0, 2 = M1
    int age;          // granted cycles so far without completion
    int last_served;  // 1 = M0, 2 = M1

    // Expected outputs for the current cycle.
    logic [1:0]    e_grant;
    logic          e_to;
    logic [31:0]   e_s_addr;
    logic [DW-1:0] e_s_data;
    logic          e_s_wv, e_s_rr;
    logic [1:0]    e_wr_ready, e_rd_valid;
    logic [DW-1:0] e_data [2];
    bit            x_req, x_hs, x_to;
    bit            m_done [2];

    // Random master bookkeeping.
    bit            act  [2];
    int            kind [2];    // 0 write, 1 read, 2 write+read (write wins)

    task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        owner       = 0;
        age         = 0;
        last_served = 2;
    endtask

    task automatic compute_expected();
        int n;
        bit wv, rd;
        e_grant = 2'b00; e_to = 1'b0; e_s_addr = '0; e_s_data = '0;
        e_s_wv = 1'b0; e_s_rr = 1'b0; e_wr_ready = 2'b00; e_rd_valid = 2'b00;
        e_data[0] = '0; e_data[1] = '0;
        x_req = 0; x_hs = 0; x_to = 0;
        if (owner != 0 && !rst) begin
            n     = owner - 1;
            wv    = m_wv[n];
            rd    = m_rr[n] && !wv;
            x_req = wv || rd;
            x_hs  = (wv && s_wr_ready) || (rd && s_rd_valid);
            x_to  = x_req && !x_hs && (age == TO - 1);
            e_grant[n] = 1'b1;
            if (x_to) begin
                e_to          = 1'b1;
                e_wr_ready[n] = wv;
                e_rd_valid[n] = rd;
            end else begin
                e_s_addr      = m_addr[n];
                e_s_data      = m_wdata[n];
                e_s_wv        = wv;
                e_s_rr        = rd;
                e_wr_ready[n] = s_wr_ready;
                e_rd_valid[n] = s_rd_valid;
                e_data[n]     = s_rdata;
            end
        end
    endtask

    task automatic compare_all();
        compute_expected();
        chk("grant",       dut_grant,       e_grant);
        chk("timeout",     dut_timeout,     e_to);
        chk("s_addr",      dut_s_addr,      e_s_addr);
        chk("s_data",      dut_s_data,      e_s_data);
        chk("s_wr_valid",  dut_s_wr_valid,  e_s_wv);
        chk("s_rd_ready",  dut_s_rd_ready,  e_s_rr);
        chk("m0_wr_ready", dut_m0_wr_ready, e_wr_ready[0]);
        chk("m0_rd_valid", dut_m0_rd_valid, e_rd_valid[0]);
        chk("m0_data",     dut_m0_data,     e_data[0]);
        chk("m1_wr_ready", dut_m1_wr_ready, e_wr_ready[1]);
        chk("m1_rd_valid", dut_m1_rd_valid, e_rd_valid[1]);
        chk("m1_data",     dut_m1_data,     e_data[1]);
    endtask

    task automatic model_advance();
        int n;
        bit r0, r1;
        if (owner == 0) begin
            r0 = m_wv[0] || m_rr[0];
            r1 = m_wv[1] || m_rr[1];
            if (r0 && r1) owner = (last_served == 2) ? 1 : 2;
            else if (r0)  owner = 1;
            else if (r1)  owner = 2;
            age = 0;
        end else begin
            n = owner - 1;
            if (x_hs || x_to) begin
                $display("txn M%0d %s addr=%08h %s", n, m_wv[n] ? "write" : "read ",
                         m_addr[n], x_to ? "timeout" : "done");
                owner       = 0;
                last_served = n + 1;
                m_done[n]   = 1;
            end else if (!x_req) begin
                $display("txn M%0d aborted by master", n);
                owner = 0;
            end else begin
                age++;
            end
        end
    endtask

    task automatic settle();
        #2;
    endtask

    // Compare this cycle, advance the model, move to the next drive point.
    task automatic step();
        compare_all();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic clear_inputs();
        for (int n = 0; n < 2; n++) begin
            m_wv[n] = 0; m_rr[n] = 0; m_addr[n] = '0; m_wdata[n] = '0;
        end
        s_wr_ready = 0; s_rd_valid = 0; s_rdata = '0;
    endtask

    task automatic random_drive();
        for (int n = 0; n < 2; n++) begin
            if (act[n] && m_done[n]) begin
                act[n] = 0;
            end else if (act[n] && $urandom_range(0, 19) == 0) begin
                act[n] = 0;
            end else if (!act[n] && $urandom_range(0, 2) == 0) begin
                act[n]     = 1;
                kind[n]    = $urandom_range(0, 2);
                m_addr[n]  = $urandom;
                m_wdata[n] = $urandom;
            end
            m_done[n] = 0;
            m_wv[n]   = act[n] && (kind[n] != 1);
            m_rr[n]   = act[n] && (kind[n] != 0);
        end
        s_wr_ready = ($urandom_range(0, 9) < 4);
        s_rd_valid = ($urandom_range(0, 9) < 4);
        s_rdata    = $urandom;
    endtask

    logic [1:0] exp_order [8];

    initial begin
        clear_inputs();
        rst = 1'b1;
        m_done[0] = 0; m_done[1] = 0;
        act[0] = 0; act[1] = 0; kind[0] = 0; kind[1] = 0;
        model_reset();

        // Reset state.
        apply_reset();
        chk("reset_grant", dut_grant, 2'b00);

        // M0 single write, slave always ready.
        m_wv[0] = 1; m_addr[0] = 32'h0000_FFFF; m_wdata[0] = 32'h41; s_wr_ready = 1;
        settle();
        chk("wr_req_cycle_s_wr_valid", dut_s_wr_valid, 1'b0);
        chk("wr_req_cycle_grant", dut_grant, 2'b00);
        step();
        settle();
        chk("wr_grant", dut_grant, 2'b01);
        chk("wr_s_wr_valid", dut_s_wr_valid, 1'b1);
        chk("wr_s_addr", dut_s_addr, 32'h0000_FFFF);
        chk("wr_s_data", dut_s_data, 32'h41);
        chk("wr_m0_wr_ready", dut_m0_wr_ready, 1'b1);
        step();
        m_wv[0] = 0;
        settle();
        chk("wr_after_grant", dut_grant, 2'b00);
        step();

        // Both masters read from reset: strict alternation with idle gaps.
        apply_reset();
        m_rr[0] = 1; m_rr[1] = 1; s_rd_valid = 1; s_rdata = 32'hDEAD_BEEF;
        exp_order[0] = 2'b00; exp_order[1] = 2'b01; exp_order[2] = 2'b00; exp_order[3] = 2'b10;
        exp_order[4] = 2'b00; exp_order[5] = 2'b01; exp_order[6] = 2'b00; exp_order[7] = 2'b10;
        for (int c = 0; c < 8; c++) begin
            settle();
            chk("rr_order", dut_grant, exp_order[c]);
            if (exp_order[c] == 2'b10) begin
                chk("rr_m1_data", dut_m1_data, 32'hDEAD_BEEF);
                chk("rr_m1_rd_valid", dut_m1_rd_valid, 1'b1);
            end
            if (exp_order[c] != 2'b01) chk("rr_m0_rd_valid_quiet", dut_m0_rd_valid, 1'b0);
            step();
        end

        // Timeout: M0 read, slave never responds.
        m_rr[1] = 0; s_rd_valid = 0; s_rdata = 32'h1234_5678;
        settle();
        chk("to_idle", dut_grant, 2'b00);
        step();
        for (int c = 1; c <= 4; c++) begin
            settle();
            chk("to_grant", dut_grant, 2'b01);
            chk("to_pulse", dut_timeout, (c == 4) ? 1'b1 : 1'b0);
            if (c == 4) begin
                chk("to_m0_rd_valid", dut_m0_rd_valid, 1'b1);
                chk("to_m0_data", dut_m0_data, 32'h0);
                chk("to_s_rd_ready", dut_s_rd_ready, 1'b0);
            end
            step();
        end
        m_rr[0] = 0;
        settle();
        chk("to_next_idle", dut_grant, 2'b00);
        step();

        // M1 withdraws mid-grant; pending M0 is served next.
        m_rr[0] = 1; m_rr[1] = 1;
        settle();
        step();
        m_rr[1] = 0;
        settle();
        chk("drop_grant", dut_grant, 2'b10);
        chk("drop_no_pulse", dut_timeout, 1'b0);
        step();
        settle();
        chk("drop_idle", dut_grant, 2'b00);
        chk("drop_idle_no_pulse", dut_timeout, 1'b0);
        step();
        settle();
        chk("drop_then_m0", dut_grant, 2'b01);
        step();
        m_rr[0] = 0;
        settle();
        step();
        settle();
        step();

        // Asynchronous reset in the middle of a GNT1 write.
        clear_inputs();
        m_wv[1] = 1; m_addr[1] = 32'hA5A5_0000; m_wdata[1] = 32'h77; s_wr_ready = 0;
        settle();
        step();
        settle();
        chk("mid_grant", dut_grant, 2'b10);
        chk("mid_s_wr_valid", dut_s_wr_valid, 1'b1);
        s_wr_ready = 1;
        rst = 1'b1;
        #1;
        chk("async_grant", dut_grant, 2'b00);
        chk("async_s_wr_valid", dut_s_wr_valid, 1'b0);
        chk("async_s_addr", dut_s_addr, 32'h0);
        chk("async_m1_wr_ready", dut_m1_wr_ready, 1'b0);
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        s_wr_ready = 0;
        m_rr[0] = 1;
        settle();
        chk("post_reset_idle", dut_grant, 2'b00);
        step();
        settle();
        chk("post_reset_tie_m0", dut_grant, 2'b01);
        step();

        // Randomized traffic against the model.
        m_done[0] = 0; m_done[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            random_drive();
            settle();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
